// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: FIFO-buffered parallel-to-serial feeder with optional inter-word gap.
// Define SERIALIZER_LSB_FIRST_EN to shift words out LSB first (default MSB first).
module bit_stream_serializer #(
    parameter int   W          = 8,
    parameter int   DEPTH      = 4,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  data_in,
    input  logic          data_valid,
    output logic          data_ready,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          frame_start,
    output logic [15:0]   words_sent
);
    localparam int CW = $clog2(W);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic          full, empty, push, pop;
    logic [W-1:0]  head;
    state_t        state_q, state_d;
    logic [W-1:0]  sh_q, sh_d, sh_shift;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gcnt_q, gcnt_d;
    logic [15:0]   ws_q, ws_d;
    logic          bit_d, bit_out_q, bit_valid_q, frame_start_q;

    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty      = wptr_q == rptr_q;
    assign data_ready = !full && !rst;
    assign push       = data_valid && data_ready;
    assign head       = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= data_in;
    end

    // Rotate rather than zero-fill: the wrapped bit is never observed since cnt bounds the word.
`ifdef SERIALIZER_LSB_FIRST_EN
    assign sh_shift = {sh_q[0], sh_q[W-1:1]};
    assign bit_d    = sh_d[0];
`else
    assign sh_shift = {sh_q[W-2:0], sh_q[W-1]};
    assign bit_d    = sh_d[W-1];
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        ws_d    = ws_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                    sh_d    = head;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                sh_d  = sh_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    ws_d = ws_q + 16'd1;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gcnt_d  = GAP_INIT;
                    end else if (!empty) begin
                        pop   = 1'b1;
                        sh_d  = head;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gcnt_q != 4'd0) begin
                    gcnt_d = gcnt_q - 4'd1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                    sh_d    = head;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so the first bit appears one edge after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sh_q          <= '0;
            cnt_q         <= '0;
            gcnt_q        <= '0;
            ws_q          <= '0;
            bit_out_q     <= IDLE_BIT;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            gcnt_q        <= gcnt_d;
            ws_q          <= ws_d;
            bit_out_q     <= (state_d == SHIFT) ? bit_d : IDLE_BIT;
            bit_valid_q   <= state_d == SHIFT;
            frame_start_q <= (state_d == SHIFT) && (cnt_d == '0);
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign words_sent  = ws_q;
endmodule
